fnd_scan_ctrl: RTL and testbench
================================

// Module: fnd_scan_ctrl
// PURPOSE
// Downstream display stage for the adder datapath. Accepts a binary result with a valid strobe and
// converts it to four BCD digits using an iterative shift-add-3 (double-dabble) FSM.
// Time-multiplexes the digits onto a 4-digit common-anode FND with a prescaled scan counter.
// Replaces free-running scan logic and combinational %/÷ digit splitting with a registered, tear-free display.
// PARAMETERS
// DATA_W    9        input width, legal 1..14 (9 = 8-bit sum + carry)
// SCAN_DIV  100000   clk cycles per digit slot (1 kHz digit rate @100 MHz); legal >=2
// PORTS
// clk         in   1        system clock, all logic on posedge
// reset       in   1        synchronous, active-high
// i_data      in   DATA_W   unsigned binary value to display
// i_valid     in   1        1-cycle strobe; i_data sampled when i_valid & ~o_busy
// o_busy      out  1        conversion in progress; new strobes ignored
// o_overflow  out  1        last accepted value > 9999
// o_fnd_com   out  4        digit enables, active-low; [0]=ones .. [3]=thousands
// o_fnd_data  out  8        segments {dp,g..a}, active-low
// BEHAVIOUR
// - Reset (sync, active-high): FSM=IDLE, o_busy=0, o_overflow=0, display digits=0, scan idx=0,
//   prescaler=0, o_fnd_com=4'b1110, o_fnd_data=8'hC0. A reset mid-conversion aborts it; display shows 0.
// - FSM IDLE: on i_valid=1, latch i_data into shift reg, clear 16-bit BCD reg,
//   record ovf=(i_data>9999), go to SHIFT, o_busy=1 from next cycle. Otherwise stay IDLE.
// - FSM SHIFT: runs exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >=5, then
//   shift {bcd,bin} left by 1. Bits shifted out of the BCD MSB are discarded (only the overflow case produces them).
// - FSM DONE (1 cycle): commit the 4 BCD nibbles to the display regs, o_overflow<=ovf, o_busy<=0, then go to IDLE.
// - Latency: if accepted at edge N, o_busy is high for DATA_W+1 cycles (after edges N..N+DATA_W).
//   Display regs update at edge N+DATA_W+1; o_fnd_data reflects the new value from edge N+DATA_W+2.
// - The display holds the previous value for the whole conversion, so there is no partial or torn display.
// - i_valid while o_busy=1 is dropped with no queueing. An i_valid in the same cycle DONE commits is also dropped.
// - Scan: the prescaler counts 0..SCAN_DIV-1 and wraps. At terminal count, idx<=idx+1 mod 4 (3->0).
//   o_fnd_com: idx0=1110, idx1=1101, idx2=1011, idx3=0111. Exactly one digit is low at all times after reset.
// - o_fnd_com and o_fnd_data are registered every cycle from the current idx and display regs.
//   Both change on the same edge, so there is no ghosting from skew.
// - Segment map: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90. Blank=FF, dash=BF. Any nibble >9 maps to FF.
// - Overflow: when o_overflow=1, all four digits show BF regardless of BCD content.
//   The flag persists until the next accepted in-range value commits.
// - The scan runs independently of the FSM. Conversion never stalls or resets the scan.
// CONFIGURATION
// FND_LEADING_ZERO_BLANK_EN defined: thousands, hundreds and tens show FF while they and all
//   higher digits are 0. Ones always shows its digit. Overflow dashes take priority.
// FND_LEADING_ZERO_BLANK_EN undefined: all four digits always show their value (0042 -> C0,C0,99,A4).
// TESTING (SCAN_DIV=4 unless noted)
// 1. Hold reset 3 cycles, then release -> o_fnd_com=1110, o_fnd_data=C0, o_busy=0, o_overflow=0.
// 2. DATA_W=9, i_data=255 with 1-cycle i_valid -> o_busy high 10 cycles.
//    Scan shows ones 92, tens 92, hundreds A4, thousands C0 (FF with FND_LEADING_ZERO_BLANK_EN).
// 3. Free run 32 cycles -> o_fnd_com steps 1110,1101,1011,0111,1110 with each pattern held 4 cycles.
//    Exactly one bit is low every cycle.
// 4. DATA_W=9, accept 255, then pulse i_valid with 100 three cycles later -> 100 is ignored and the display settles on 255.
//    Pulsing i_valid with 100 on the DONE cycle is also ignored.
// 5. DATA_W=14, i_data=10000 -> o_overflow=1 and all digits BF.
//    Then i_data=9999 -> o_overflow=0 and all digits 90.
// 6. DATA_W=9: accept 255 to completion, then accept 17 and assert reset on its 4th busy cycle.
//    -> next cycle o_busy=0, the display is all-zero digits (ones C0), and o_fnd_com=1110.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed common-anode FND.
// Optional feature: define FND_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module fnd_scan_ctrl #(
    parameter int DATA_W   = 9,
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [3:0]        o_fnd_com,
    output logic [7:0]        o_fnd_data
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nx;
    logic              load, commit;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic [DATA_W-1:0] bin;
    logic [15:0]       bcd;
    logic [15:0]       disp;
    logic [PW-1:0]     pre;
    logic [1:0]        idx;
    logic [3:0]        digit;
    logic              lead_zero;
    logic [7:0]        seg_nx;

    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        for (int n = 0; n < 4; n++)
            r[n*4 +: 4] = (v[n*4 +: 4] >= 4'd5) ? v[n*4 +: 4] + 4'd3 : v[n*4 +: 4];
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nx = SHIFT;
                    load     = 1'b1;
                end
            end
            SHIFT:   if (cnt == CW'(DATA_W - 1)) state_nx = DONE;
            DONE: begin
                state_nx = IDLE;
                commit   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
            cnt        <= '0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                o_busy <= 1'b1;
                cnt    <= '0;
                ovf    <= (32'(i_data) > 32'd9999);
            end else if (state == SHIFT) begin
                cnt <= cnt + CW'(1);
            end
            if (commit) begin
                o_busy     <= 1'b0;
                o_overflow <= ovf;
            end
        end
    end

    // Conversion datapath; meaningful only between load and commit, so no reset
    always_ff @(posedge clk) begin
        if (load) begin
            bin <= i_data;
            bcd <= '0;
        end else if (state == SHIFT) begin
            {bcd, bin} <= {dd_adjust(bcd), bin} << 1;
        end
    end

    // Display holds the previous value until a conversion commits as a whole
    always_ff @(posedge clk) begin
        if (reset)       disp <= '0;
        else if (commit) disp <= bcd;
    end

    always_comb begin
        digit     = disp[{idx, 2'b00} +: 4];
        lead_zero = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        case (idx)
            2'd3:    lead_zero = (disp[15:12] == 4'd0);
            2'd2:    lead_zero = (disp[15:8] == 8'd0);
            2'd1:    lead_zero = (disp[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
`endif
        if (o_overflow)     seg_nx = 8'hBF;
        else if (lead_zero) seg_nx = 8'hFF;
        else                seg_nx = seg7(digit);
    end

    // Common and segment lines register together from the same idx, avoiding ghosting
    always_ff @(posedge clk) begin
        if (reset) begin
            pre        <= '0;
            idx        <= 2'd0;
            o_fnd_com  <= 4'b1110;
            o_fnd_data <= 8'hC0;
        end else begin
            if (pre == PS_MAX) begin
                pre <= '0;
                idx <= idx + 2'd1;
            end else begin
                pre <= pre + PW'(1);
            end
            o_fnd_com  <= ~(4'b0001 << idx);
            o_fnd_data <= seg_nx;
        end
    end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: 9-bit and 14-bit instances, SCAN_DIV=4.
module tb_fnd_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  d9 = '0;
    logic        v9 = 1'b0;
    logic        busy9, ovf9;
    logic [3:0]  com9;
    logic [7:0]  seg9;
    logic [13:0] d14 = '0;
    logic        v14 = 1'b0;
    logic        busy14, ovf14;
    logic [3:0]  com14;
    logic [7:0]  seg14;

    int checks = 0;
    int errors = 0;
    logic [7:0] seen [4];
    logic [7:0] exp_d [4];

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.DATA_W(9), .SCAN_DIV(4)) dut9 (
        .clk(clk), .reset(reset), .i_data(d9), .i_valid(v9),
        .o_busy(busy9), .o_overflow(ovf9), .o_fnd_com(com9), .o_fnd_data(seg9)
    );

    fnd_scan_ctrl #(.DATA_W(14), .SCAN_DIV(4)) dut14 (
        .clk(clk), .reset(reset), .i_data(d14), .i_valid(v14),
        .o_busy(busy14), .o_overflow(ovf14), .o_fnd_com(com14), .o_fnd_data(seg14)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watch one full scan rotation and record the segment byte shown at each digit slot
    task automatic capture(input int which);
        logic [3:0] c;
        logic [7:0] s;
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        for (int k = 0; k < 20; k++) begin
            tick();
            c = (which == 0) ? com9 : com14;
            s = (which == 0) ? seg9 : seg14;
            case (c)
                4'b1110: seen[0] = s;
                4'b1101: seen[1] = s;
                4'b1011: seen[2] = s;
                4'b0111: seen[3] = s;
                default: ;
            endcase
        end
    endtask

    task automatic accept(input int which, input int value, output int nbusy);
        if (which == 0) begin d9 = value[8:0]; v9 = 1'b1; end
        else begin d14 = value[13:0]; v14 = 1'b1; end
        tick();
        v9 = 1'b0;
        v14 = 1'b0;
        nbusy = 0;
        while (nbusy < 40 && ((which == 0) ? busy9 : busy14)) begin
            nbusy++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (com9 !== 4'b1110) begin errors++; $display("FAIL reset_com: got %b want 1110", com9); end
        checks++; if (seg9 !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h want c0", seg9); end
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy9); end
        checks++; if (ovf9 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf9); end
        checks++; if (com14 !== 4'b1110 || busy14 !== 1'b0) begin
            errors++; $display("FAIL reset_dut14: com %b busy %b want 1110 0", com14, busy14);
        end
    endtask

    task automatic test_scan();
        logic [3:0] pat [4];
        logic [3:0] want;
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            want = pat[((k - 1) / 4) % 4];
            checks++; if (com9 !== want) begin errors++; $display("FAIL scan_com cycle %0d: got %b want %b", k, com9, want); end
            checks++; if ($countones(~com9) != 1) begin errors++; $display("FAIL scan_onehot cycle %0d: got %b want one low bit", k, com9); end
        end
    endtask

    task automatic test_convert();
        int n;
        accept(0, 255, n);
        checks++; if (n != 10) begin errors++; $display("FAIL conv255_busy: got %0d cycles want 10", n); end
        capture(0);
        exp_d[0] = 8'h92; exp_d[1] = 8'h92; exp_d[2] = 8'hA4;
`ifdef FND_LEADING_ZERO_BLANK_EN
        exp_d[3] = 8'hFF;
`else
        exp_d[3] = 8'hC0;
`endif
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== exp_d[i]) begin errors++; $display("FAIL conv255_digit%0d: got %h want %h", i, seen[i], exp_d[i]); end
        end
        checks++; if (ovf9 !== 1'b0) begin errors++; $display("FAIL conv255_ovf: got %b want 0", ovf9); end
    endtask

    task automatic test_overflow();
        int n;
        accept(1, 10000, n);
        checks++; if (n != 15) begin errors++; $display("FAIL ovf_busy: got %0d cycles want 15", n); end
        capture(1);
        checks++; if (ovf14 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf14); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== 8'hBF) begin errors++; $display("FAIL ovf_digit%0d: got %h want bf", i, seen[i]); end
        end
        accept(1, 9999, n);
        capture(1);
        checks++; if (ovf14 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf14); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== 8'h90) begin errors++; $display("FAIL n9999_digit%0d: got %h want 90", i, seen[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        accept(0, 42, n);
        // 255 accepted, then 100 offered three cycles later while busy
        d9 = 9'd255; v9 = 1'b1;
        tick();
        v9 = 1'b0;
        n = busy9 ? 1 : 0;
        tick(); if (busy9) n++;
        tick(); if (busy9) n++;
        d9 = 9'd100; v9 = 1'b1;
        tick();
        v9 = 1'b0;
        if (busy9) n++;
        while (n < 40 && busy9) begin
            tick();
            if (busy9) n++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL drop_busy: got %0d cycles want 10", n); end
        capture(0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== exp_d[i]) begin errors++; $display("FAIL drop_digit%0d: got %h want %h", i, seen[i], exp_d[i]); end
        end
        // 100 offered exactly on the DONE cycle
        d9 = 9'd255; v9 = 1'b1;
        tick();
        v9 = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        checks++; if (busy9 !== 1'b1) begin errors++; $display("FAIL done_cycle_busy: got %b want 1", busy9); end
        d9 = 9'd100; v9 = 1'b1;
        tick();
        v9 = 1'b0;
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL done_drop_busy0: got %b want 0", busy9); end
        tick();
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL done_drop_busy1: got %b want 0", busy9); end
        capture(0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== exp_d[i]) begin errors++; $display("FAIL done_drop_digit%0d: got %h want %h", i, seen[i], exp_d[i]); end
        end
    endtask

    task automatic test_reset_abort();
        int n;
        accept(0, 255, n);
        d9 = 9'd17; v9 = 1'b1;
        tick();
        v9 = 1'b0;
        repeat (3) tick();
        checks++; if (busy9 !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy9); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy9); end
        checks++; if (com9 !== 4'b1110) begin errors++; $display("FAIL abort_com: got %b want 1110", com9); end
        checks++; if (seg9 !== 8'hC0) begin errors++; $display("FAIL abort_seg: got %h want c0", seg9); end
        capture(0);
`ifdef FND_LEADING_ZERO_BLANK_EN
        exp_d[0] = 8'hC0; exp_d[1] = 8'hFF; exp_d[2] = 8'hFF; exp_d[3] = 8'hFF;
`else
        exp_d[0] = 8'hC0; exp_d[1] = 8'hC0; exp_d[2] = 8'hC0; exp_d[3] = 8'hC0;
`endif
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== exp_d[i]) begin errors++; $display("FAIL abort_digit%0d: got %h want %h", i, seen[i], exp_d[i]); end
        end
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy9); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
